// File: rtl/spi_xfer_sequencer.sv
// Master-mode SPI byte sequencer: drives SCLK/SS and the load, capture, edge-warning
// and drive/sample strobes for an external 8-bit shift register.
module spi_xfer_sequencer #(
    parameter int unsigned DIV_W = 12
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             spe,
    input  logic             mstr,
    input  logic             start,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [DIV_W-1:0] baud_div,
    output logic             busy,
    output logic             ss,
    output logic             sclk,
    output logic             send_data,
    output logic             receive_data,
    output logic             flag_high,
    output logic             flag_low,
    output logic             flags_high,
    output logic             flags_low,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, LOAD, XFER, DONE} state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n, div_q, div_n;
    logic [3:0]       edge_cnt, edge_n;
    logic             tail, tail_n;
    logic             cpha_q, cpha_n;
    logic             sclk_n;
    logic             send_n, recv_n, done_n, sh_n, sl_n, fh_n, fl_n;

    // Next-state and next-output computation; every output register is loaded from here.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        edge_n   = edge_cnt;
        tail_n   = tail;
        div_n    = div_q;
        cpha_n   = cpha_q;
        sclk_n   = sclk;
        send_n   = 1'b0;
        recv_n   = 1'b0;
        done_n   = 1'b0;
        sh_n     = 1'b0;
        sl_n     = 1'b0;
        fh_n     = 1'b0;
        fl_n     = 1'b0;
        unique case (state)
            IDLE: begin
                sclk_n = cpol;
                if (start && spe && mstr) begin
                    state_n = LOAD;
                    div_n   = baud_div;
                    cpha_n  = cpha;
                    cnt_n   = baud_div;
                    edge_n  = 4'd0;
                    tail_n  = 1'b0;
                    send_n  = 1'b1;
                end
            end
            LOAD, XFER: begin
                state_n = XFER;
                if (cnt == '0) begin
                    cnt_n = div_q;
                    if (tail) begin
                        state_n = DONE;
                        recv_n  = 1'b1;
                        done_n  = 1'b1;
                    end else begin
                        sclk_n = ~sclk;
                        // Even edges lead; sample on leading edges when cpha=0, trailing when cpha=1.
                        if (edge_cnt[0] == cpha_q) begin
                            sh_n = 1'b1;
                        end else begin
                            sl_n = cpha_q ? (edge_cnt != 4'd0) : (edge_cnt != 4'd15);
                        end
                        if (edge_cnt == 4'd15) begin
                            tail_n = 1'b1;
                        end else begin
                            edge_n = edge_cnt + 4'd1;
                        end
                    end
                end else begin
                    cnt_n = cnt - DIV_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                sclk_n  = cpol;
            end
        endcase
        // Disabling the block abandons the byte without capture or completion.
        if (state != IDLE && !spe) begin
            state_n = IDLE;
            sclk_n  = cpol;
            send_n  = 1'b0;
            recv_n  = 1'b0;
            done_n  = 1'b0;
            sh_n    = 1'b0;
            sl_n    = 1'b0;
        end
        // Warn one cycle ahead: next cycle's counter hits zero with edges still pending.
        if ((state_n == LOAD || state_n == XFER) && !tail_n && cnt_n == '0) begin
            fh_n = ~sclk_n;
            fl_n = sclk_n;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state        <= IDLE;
            cnt          <= '0;
            div_q        <= '0;
            edge_cnt     <= 4'd0;
            tail         <= 1'b0;
            cpha_q       <= 1'b0;
            sclk         <= cpol;
            busy         <= 1'b0;
            ss           <= 1'b1;
            send_data    <= 1'b0;
            receive_data <= 1'b0;
            flag_high    <= 1'b0;
            flag_low     <= 1'b0;
            flags_high   <= 1'b0;
            flags_low    <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            div_q        <= div_n;
            edge_cnt     <= edge_n;
            tail         <= tail_n;
            cpha_q       <= cpha_n;
            sclk         <= sclk_n;
            busy         <= (state_n != IDLE);
            ss           <= (state_n == IDLE);
            send_data    <= send_n;
            receive_data <= recv_n;
            flag_high    <= fh_n;
            flag_low     <= fl_n;
            flags_high   <= sh_n;
            flags_low    <= sl_n;
            done         <= done_n;
        end
    end

endmodule
